// File: rtl/bf16_accum_ctrl.sv
// ============================================================================
// Module   : bf16_accum_ctrl
// Brief    : Sequences a valid/ready stream of bf16 terms through an external
//            combinational adder and presents each LEN-term sum downstream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bf16_accum_ctrl #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [15:0] add_a,
    output logic        add_a_vld,
    output logic [15:0] add_b,
    output logic        add_b_vld,
    input  logic [15:0] add_z,
    input  logic        add_z_vld,
    output logic [15:0] out_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        out_exc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_vld_q, out_vld_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_exc_q, out_exc_d;
    logic               w_accept;

    // Ready is held low while reset is asserted so nothing is taken mid-reset.
    assign in_rdy    = rst_n & (state_q != ST_DONE) & ~clr;
    assign w_accept  = in_vld & in_rdy;

    assign add_a     = acc_q;
    assign add_b     = in_data;
    assign add_a_vld = (state_q == ST_ACC);
    assign add_b_vld = in_vld & (state_q == ST_ACC);

    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign out_exc   = out_exc_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;

        if (clr) begin
            state_d    = ST_IDLE;
            acc_d      = 16'h0000;
            cnt_d      = '0;
            out_vld_d  = 1'b0;
            out_data_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        acc_d = in_data;
                        cnt_d = C_ONE;
                        if (LEN == 1) begin
                            state_d    = ST_DONE;
                            out_vld_d  = 1'b1;
                            out_data_d = in_data;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept && add_z_vld) begin
                        acc_d = add_z;
                        cnt_d = cnt_q + C_ONE;
                        if (cnt_q == C_LAST) begin
                            state_d    = ST_DONE;
                            out_vld_d  = 1'b1;
                            out_data_d = add_z;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        out_vld_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Exception flag follows the presented word and is only raised while valid.
        out_exc_d = out_vld_d & (out_data_d[14:7] == 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= 16'h0000;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= 16'h0000;
            out_exc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_exc_q  <= out_exc_d;
        end
    end

endmodule

`default_nettype wire
